// File: rtl/wb_trap_ctrl.sv
// Write-back trap controller: prioritises IRQs/exceptions, drives CSR trap/mret writes, flush/redirect and WFI stall.
// Trap outputs are combinational on the trigger cycle; redirect_pc_o is registered; IRQ inputs add IRQ_SYNC_STAGES cycles.
module wb_trap_ctrl #(
    parameter int NUM_PLAT_IRQ    = 4,
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wb_valid_i,
    input  logic [31:0]             wb_pc_i,
    input  logic [31:0]             wb_inst_i,
    input  logic [31:0]             wb_badaddr_i,
    input  logic [5:0]              exc_i,
    input  logic                    is_mret_i,
    input  logic                    is_wfi_i,
    input  logic                    xint_meip_i,
    input  logic                    xint_mtip_i,
    input  logic                    xint_msip_i,
    input  logic [NUM_PLAT_IRQ-1:0] plat_irq_i,
    input  logic [31:0]             csr_mie_i,
    input  logic                    csr_gie_i,
    input  logic [31:0]             csr_mtvec_i,
    input  logic [31:0]             csr_mepc_i,
    input  logic                    flush_ack_i,
    output logic [31:0]             mip_o,
    output logic                    trap_we_o,
    output logic [31:0]             trap_cause_o,
    output logic [31:0]             trap_epc_o,
    output logic [31:0]             trap_tval_o,
    output logic                    mret_o,
    output logic                    retire_ok_o,
    output logic                    flush_o,
    output logic                    redirect_o,
    output logic [31:0]             redirect_pc_o,
    output logic                    stall_o
);
    localparam int NL = NUM_PLAT_IRQ + 3;

    typedef enum logic [1:0] {IDLE, FLUSH, WFI} state_t;

    state_t          state_q, state_d;
    logic [NL-1:0]   sync_q [IRQ_SYNC_STAGES];
    logic [NL-1:0]   irq_s;
    logic [31:0]     pend;
    logic            pend_any;
    logic            irq_take;
    logic [4:0]      irq_idx;
    logic [4:0]      exc_cause;
    logic [31:0]     exc_tval;
    logic            exc_any;
    logic            is_irq;
    logic            wfi_enter;
    logic [31:0]     trap_base;
    logic [31:0]     trap_target;
    logic [31:0]     wfi_pc_q;

    // Line order in the synchroniser: {plat, meip, mtip, msip}
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < IRQ_SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= {plat_irq_i, xint_meip_i, xint_mtip_i, xint_msip_i};
            for (int s = 1; s < IRQ_SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign irq_s = sync_q[IRQ_SYNC_STAGES-1];

    always_comb begin
        mip_o     = '0;
        mip_o[3]  = irq_s[0];
        mip_o[7]  = irq_s[1];
        mip_o[11] = irq_s[2];
        for (int i = 0; i < NUM_PLAT_IRQ; i++) mip_o[16+i] = irq_s[3+i];
    end

    assign pend     = mip_o & csr_mie_i;
    assign pend_any = |pend;
    assign irq_take = pend_any & csr_gie_i;
    assign exc_any  = |exc_i;

    // Later assignments win, so the highest priority source is checked last.
    always_comb begin
        irq_idx = 5'd0;
        for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--)
            if (pend[16+i]) irq_idx = 5'(16 + i);
        if (pend[7])  irq_idx = 5'd7;
        if (pend[3])  irq_idx = 5'd3;
        if (pend[11]) irq_idx = 5'd11;
    end

    always_comb begin
        exc_cause = 5'd0;
        exc_tval  = '0;
        if (exc_i[3]) begin exc_cause = 5'd4;  exc_tval = wb_badaddr_i; end
        if (exc_i[4]) begin exc_cause = 5'd6;  exc_tval = wb_badaddr_i; end
        if (exc_i[5]) begin exc_cause = 5'd11; exc_tval = '0;           end
        if (exc_i[2]) begin exc_cause = 5'd3;  exc_tval = wb_pc_i;      end
        if (exc_i[0]) begin exc_cause = 5'd0;  exc_tval = wb_badaddr_i; end
        if (exc_i[1]) begin exc_cause = 5'd2;  exc_tval = wb_inst_i;    end
    end

    assign trap_base   = {csr_mtvec_i[31:2], 2'b00};
    assign trap_target = (is_irq && csr_mtvec_i[1:0] == 2'b01)
                       ? trap_base + {25'd0, irq_idx, 2'b00} : trap_base;

    always_comb begin
        state_d      = state_q;
        trap_we_o    = 1'b0;
        trap_cause_o = '0;
        trap_epc_o   = '0;
        trap_tval_o  = '0;
        mret_o       = 1'b0;
        retire_ok_o  = 1'b0;
        flush_o      = 1'b0;
        redirect_o   = 1'b0;
        stall_o      = 1'b0;
        is_irq       = 1'b0;
        wfi_enter    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wb_valid_i) begin
                    if (irq_take || exc_any) begin
                        trap_we_o  = 1'b1;
                        is_irq     = irq_take;
                        trap_epc_o = wb_pc_i;
                        state_d    = FLUSH;
                    end else if (is_mret_i) begin
                        mret_o      = 1'b1;
                        retire_ok_o = 1'b1;
                        state_d     = FLUSH;
                    end else if (is_wfi_i) begin
                        retire_ok_o = 1'b1;
                        wfi_enter   = 1'b1;
                        state_d     = WFI;
                    end else begin
                        retire_ok_o = 1'b1;
                    end
                end
            end
            FLUSH: begin
                flush_o = 1'b1;
                if (flush_ack_i) begin
                    redirect_o = 1'b1;
                    state_d    = IDLE;
                end
            end
            WFI: begin
                stall_o = 1'b1;
                if (pend_any) begin
                    if (csr_gie_i) begin
                        trap_we_o  = 1'b1;
                        is_irq     = 1'b1;
                        trap_epc_o = wfi_pc_q;
                        state_d    = FLUSH;
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (trap_we_o) begin
            trap_cause_o = is_irq ? {1'b1, 26'd0, irq_idx} : {27'd0, exc_cause};
            trap_tval_o  = is_irq ? 32'd0 : exc_tval;
        end
        if (rst_i) begin
            trap_we_o    = 1'b0;
            trap_cause_o = '0;
            trap_epc_o   = '0;
            trap_tval_o  = '0;
            mret_o       = 1'b0;
            retire_ok_o  = 1'b0;
            flush_o      = 1'b0;
            redirect_o   = 1'b0;
            stall_o      = 1'b0;
            wfi_enter    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            redirect_pc_o <= '0;
            wfi_pc_q      <= '0;
        end else begin
            state_q <= state_d;
            if (trap_we_o)   redirect_pc_o <= trap_target;
            else if (mret_o) redirect_pc_o <= csr_mepc_i;
            if (wfi_enter)   wfi_pc_q <= wb_pc_i + 32'd4;
        end
    end
endmodule

// File: tb/tb_wb_trap_ctrl.sv
// Directed bench for wb_trap_ctrl: reset, exception/IRQ priority, vectoring, WFI, mret, flush handshake.
module tb_wb_trap_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_valid_i;
    logic [31:0] wb_pc_i, wb_inst_i, wb_badaddr_i;
    logic [5:0]  exc_i;
    logic        is_mret_i, is_wfi_i;
    logic        xint_meip_i, xint_mtip_i, xint_msip_i;
    logic [3:0]  plat_irq_i;
    logic [31:0] csr_mie_i;
    logic        csr_gie_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i;
    logic        flush_ack_i;
    logic [31:0] mip_o;
    logic        trap_we_o;
    logic [31:0] trap_cause_o, trap_epc_o, trap_tval_o;
    logic        mret_o, retire_ok_o, flush_o, redirect_o;
    logic [31:0] redirect_pc_o;
    logic        stall_o;

    int n_cmp = 0;
    int n_err = 0;

    wb_trap_ctrl #(.NUM_PLAT_IRQ(4), .IRQ_SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i),
        .wb_inst_i(wb_inst_i), .wb_badaddr_i(wb_badaddr_i), .exc_i(exc_i),
        .is_mret_i(is_mret_i), .is_wfi_i(is_wfi_i), .xint_meip_i(xint_meip_i),
        .xint_mtip_i(xint_mtip_i), .xint_msip_i(xint_msip_i), .plat_irq_i(plat_irq_i),
        .csr_mie_i(csr_mie_i), .csr_gie_i(csr_gie_i), .csr_mtvec_i(csr_mtvec_i),
        .csr_mepc_i(csr_mepc_i), .flush_ack_i(flush_ack_i), .mip_o(mip_o),
        .trap_we_o(trap_we_o), .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o),
        .trap_tval_o(trap_tval_o), .mret_o(mret_o), .retire_ok_o(retire_ok_o),
        .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; wb_valid_i = 1'b0; wb_pc_i = '0; wb_inst_i = '0; wb_badaddr_i = '0;
        exc_i = '0; is_mret_i = 1'b0; is_wfi_i = 1'b0; xint_meip_i = 1'b0; xint_mtip_i = 1'b0;
        xint_msip_i = 1'b0; plat_irq_i = '0; csr_mie_i = '0; csr_gie_i = 1'b0;
        csr_mtvec_i = 32'h200; csr_mepc_i = '0; flush_ack_i = 1'b0;
        cyc(); cyc();
        chk("rst_trap_we", {31'd0, trap_we_o}, 32'd0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_mip", mip_o, 32'd0);
        chk("rst_redir_pc", redirect_pc_o, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_retire", {31'd0, retire_ok_o}, 32'd0);
        rst_i = 1'b0;

        // illegal instruction, non-vectored
        wb_valid_i = 1'b1; wb_pc_i = 32'h100; wb_inst_i = 32'hFFFF_FFFF; exc_i = 6'b000010;
        #1;
        chk("ill_we", {31'd0, trap_we_o}, 32'd1);
        chk("ill_cause", trap_cause_o, 32'd2);
        chk("ill_tval", trap_tval_o, 32'hFFFF_FFFF);
        chk("ill_epc", trap_epc_o, 32'h100);
        chk("ill_retire", {31'd0, retire_ok_o}, 32'd0);
        cyc();
        wb_valid_i = 1'b0; exc_i = '0;
        #1;
        chk("ill_flush1", {31'd0, flush_o}, 32'd1);
        chk("ill_noredir", {31'd0, redirect_o}, 32'd0);
        chk("ill_noretwe", {31'd0, trap_we_o}, 32'd0);
        cyc();
        wb_valid_i = 1'b1; wb_pc_i = 32'h104; wb_inst_i = 32'h13;
        #1;
        chk("flush_hold", {31'd0, flush_o}, 32'd1);
        chk("flush_noretire", {31'd0, retire_ok_o}, 32'd0);
        wb_valid_i = 1'b0; flush_ack_i = 1'b1;
        #1;
        chk("ill_redir", {31'd0, redirect_o}, 32'd1);
        chk("ill_redir_pc", redirect_pc_o, 32'h200);
        cyc();
        flush_ack_i = 1'b0;
        #1;
        chk("ill_flush_drop", {31'd0, flush_o}, 32'd0);
        chk("ill_redir_drop", {31'd0, redirect_o}, 32'd0);

        // reset in the middle of FLUSH
        wb_valid_i = 1'b1; wb_pc_i = 32'h108; wb_inst_i = 32'hFFFF_FFFF; exc_i = 6'b000010;
        cyc();
        wb_valid_i = 1'b0; exc_i = '0; rst_i = 1'b1; xint_meip_i = 1'b1;
        cyc(); cyc();
        chk("mrst_flush", {31'd0, flush_o}, 32'd0);
        chk("mrst_mip", mip_o, 32'd0);
        chk("mrst_redir_pc", redirect_pc_o, 32'd0);
        xint_meip_i = 1'b0; rst_i = 1'b0; flush_ack_i = 1'b1;
        #1;
        chk("mrst_noredir", {31'd0, redirect_o}, 32'd0);
        chk("mrst_flush2", {31'd0, flush_o}, 32'd0);
        cyc();
        flush_ack_i = 1'b0;

        // timer IRQ, vectored mtvec
        csr_mtvec_i = 32'h201; csr_mie_i = 32'h80; csr_gie_i = 1'b1; xint_mtip_i = 1'b1;
        cyc();
        chk("mtip_lat1", mip_o, 32'd0);
        cyc();
        chk("mtip_lat2", mip_o, 32'h80);
        wb_valid_i = 1'b1; wb_pc_i = 32'h40; wb_inst_i = 32'h13;
        #1;
        chk("mti_cause", trap_cause_o, 32'h8000_0007);
        chk("mti_epc", trap_epc_o, 32'h40);
        chk("mti_tval", trap_tval_o, 32'd0);
        chk("mti_retire", {31'd0, retire_ok_o}, 32'd0);
        cyc();
        wb_valid_i = 1'b0; xint_mtip_i = 1'b0; csr_mie_i = '0; flush_ack_i = 1'b1;
        #1;
        chk("mti_redir_pc", redirect_pc_o, 32'h21C);
        cyc();
        flush_ack_i = 1'b0; csr_mtvec_i = 32'h200;

        // MEIP beats ld_mis
        csr_mie_i = 32'h800; xint_meip_i = 1'b1;
        cyc(); cyc();
        wb_valid_i = 1'b1; wb_pc_i = 32'h50; exc_i = 6'b001000; wb_badaddr_i = 32'h1233;
        #1;
        chk("mei_cause", trap_cause_o, 32'h8000_000B);
        chk("mei_tval", trap_tval_o, 32'd0);
        cyc();
        wb_valid_i = 1'b0; exc_i = '0; xint_meip_i = 1'b0; csr_mie_i = '0; flush_ack_i = 1'b1;
        #1;
        chk("mei_redir_pc", redirect_pc_o, 32'h200);
        cyc();
        flush_ack_i = 1'b0;
        cyc(); cyc();

        // illegal beats st_mis
        wb_valid_i = 1'b1; wb_pc_i = 32'h60; wb_inst_i = 32'hDEAD_BEEF; exc_i = 6'b010010;
        wb_badaddr_i = 32'h77;
        #1;
        chk("ill_st_cause", trap_cause_o, 32'd2);
        chk("ill_st_tval", trap_tval_o, 32'hDEAD_BEEF);
        cyc();
        wb_valid_i = 1'b0; exc_i = '0; flush_ack_i = 1'b1;
        cyc();
        flush_ack_i = 1'b0;

        // st_mis beats ld_mis
        wb_valid_i = 1'b1; wb_pc_i = 32'h64; exc_i = 6'b011000; wb_badaddr_i = 32'h99;
        #1;
        chk("st_ld_cause", trap_cause_o, 32'd6);
        chk("st_ld_tval", trap_tval_o, 32'h99);
        cyc();
        wb_valid_i = 1'b0; exc_i = '0; flush_ack_i = 1'b1;
        cyc();
        flush_ack_i = 1'b0;

        // WFI woken with gie=0: no trap
        csr_gie_i = 1'b0; csr_mie_i = 32'h8;
        wb_valid_i = 1'b1; wb_pc_i = 32'h80; is_wfi_i = 1'b1;
        #1;
        chk("wfi_retire", {31'd0, retire_ok_o}, 32'd1);
        cyc();
        wb_valid_i = 1'b0; is_wfi_i = 1'b0;
        #1;
        chk("wfi_stall", {31'd0, stall_o}, 32'd1);
        xint_msip_i = 1'b1;
        cyc();
        chk("wfi_stall2", {31'd0, stall_o}, 32'd1);
        cyc();
        chk("wfi_g0_notrap", {31'd0, trap_we_o}, 32'd0);
        cyc();
        chk("wfi_g0_exit", {31'd0, stall_o}, 32'd0);
        chk("wfi_g0_noflush", {31'd0, flush_o}, 32'd0);
        xint_msip_i = 1'b0;
        cyc(); cyc();

        // WFI woken with gie=1: trap with epc = pc+4
        csr_gie_i = 1'b1;
        wb_valid_i = 1'b1; wb_pc_i = 32'h80; is_wfi_i = 1'b1;
        cyc();
        wb_valid_i = 1'b0; is_wfi_i = 1'b0; xint_msip_i = 1'b1;
        cyc(); cyc();
        chk("wfi_g1_we", {31'd0, trap_we_o}, 32'd1);
        chk("wfi_g1_cause", trap_cause_o, 32'h8000_0003);
        chk("wfi_g1_epc", trap_epc_o, 32'h84);
        cyc();
        xint_msip_i = 1'b0;
        #1;
        chk("wfi_g1_stall", {31'd0, stall_o}, 32'd0);
        chk("wfi_g1_flush", {31'd0, flush_o}, 32'd1);
        flush_ack_i = 1'b1;
        #1;
        chk("wfi_g1_redir_pc", redirect_pc_o, 32'h200);
        cyc();
        flush_ack_i = 1'b0; csr_mie_i = '0;
        cyc(); cyc();

        // platform IRQ 1
        csr_mie_i = 32'h2_0000; plat_irq_i = 4'b0010;
        cyc(); cyc();
        chk("plat_mip", mip_o, 32'h2_0000);
        wb_valid_i = 1'b1; wb_pc_i = 32'h90;
        #1;
        chk("plat_cause", trap_cause_o, 32'h8000_0011);
        cyc();
        wb_valid_i = 1'b0; plat_irq_i = '0; csr_mie_i = '0; flush_ack_i = 1'b1;
        cyc();
        flush_ack_i = 1'b0;
        cyc(); cyc();

        // mret
        csr_mepc_i = 32'h300; wb_valid_i = 1'b1; wb_pc_i = 32'hA0; is_mret_i = 1'b1;
        #1;
        chk("mret_pulse", {31'd0, mret_o}, 32'd1);
        chk("mret_notrap", {31'd0, trap_we_o}, 32'd0);
        chk("mret_retire", {31'd0, retire_ok_o}, 32'd1);
        cyc();
        wb_valid_i = 1'b0; is_mret_i = 1'b0;
        #1;
        chk("mret_flush", {31'd0, flush_o}, 32'd1);
        chk("mret_pulse_end", {31'd0, mret_o}, 32'd0);
        flush_ack_i = 1'b1;
        #1;
        chk("mret_redir", {31'd0, redirect_o}, 32'd1);
        chk("mret_redir_pc", redirect_pc_o, 32'h300);
        cyc();
        flush_ack_i = 1'b0;

        // ecall with mret: exception wins, tval 0
        wb_valid_i = 1'b1; wb_pc_i = 32'hB0; is_mret_i = 1'b1; exc_i = 6'b100000;
        #1;
        chk("ecall_cause", trap_cause_o, 32'd11);
        chk("ecall_tval", trap_tval_o, 32'd0);
        chk("ecall_nomret", {31'd0, mret_o}, 32'd0);
        cyc();
        wb_valid_i = 1'b0; is_mret_i = 1'b0; exc_i = '0; flush_ack_i = 1'b1;
        cyc();
        flush_ack_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
